// File: rtl/mux32_serializer.sv
// mux32_serializer: captures a 32-bit word and shifts out len+1 bits, one per transfer, through a mux32.
// Latency: first bit is valid right after the accepting edge; consecutive words run with no bubble.
// Backpressure: sout_ready low freezes sel/data_q/sout; in_ready reopens on the last bit's transfer.
module mux32_serializer #(
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] in_data,
   input  logic [4:0]  in_len,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        sout,
   output logic        sout_valid,
   input  logic        sout_ready,
   output logic        sout_last,
   output logic [4:0]  sel,
   output logic        busy
);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] data_q;
   logic [31:0] data_nxt;
   logic [4:0]  sel_nxt;
   logic [4:0]  end_q;
   logic [4:0]  end_nxt;
   logic        accept;
   logic        bit_xfer;

   // Outputs decode straight from registers; only in_ready looks at sout_ready.
   assign sout_valid = (state == SHIFT);
   assign busy       = (state == SHIFT);
   assign sout_last  = (state == SHIFT) && (sel == end_q);
   assign bit_xfer   = sout_valid & sout_ready;
   assign in_ready   = (state == IDLE) | (bit_xfer & sout_last);
   assign accept     = in_valid & in_ready;

   // The serial bit itself comes from the bit-select mux driven by the held word.
   mux32 u_mux (
      .in  (data_q),
      .ena (sel),
      .out (sout)
   );

   // Next-state: step the select on each transfer; an accept (possibly on the last bit) reloads everything.
   always_comb begin
      state_nxt = state;
      data_nxt  = data_q;
      sel_nxt   = sel;
      end_nxt   = end_q;
      if (bit_xfer) begin
         if (!sout_last) begin
            sel_nxt = MSB_FIRST ? (sel - 5'd1) : (sel + 5'd1);
         end else begin
            state_nxt = IDLE;
            sel_nxt   = 5'd0;
         end
      end
      if (accept) begin
         data_nxt  = in_data;
         sel_nxt   = MSB_FIRST ? in_len : 5'd0;
         end_nxt   = MSB_FIRST ? 5'd0 : in_len;
         state_nxt = SHIFT;
      end
   end

   // State and datapath registers; reset drops any word in flight immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         data_q <= 32'd0;
         sel    <= 5'd0;
         end_q  <= 5'd0;
      end else begin
         state  <= state_nxt;
         data_q <= data_nxt;
         sel    <= sel_nxt;
         end_q  <= end_nxt;
      end
   end

endmodule

// mux32: 32:1 bit-select mux, out = in[ena].
// Latency: purely combinational.
// Backpressure: none; no handshake on this block.
module mux32 (
   input  logic [31:0] in,
   input  logic [4:0]  ena,
   output logic        out
);
   assign out = in[ena];
endmodule

// File: tb/tb_mux32_serializer.sv
// tb_mux32_serializer: drives an LSB-first and an MSB-first instance with the same handshakes.
// Latency: a reference queue of expected bits per instance is compared every cycle.
// Backpressure: sout_ready follows fixed patterns or $urandom.
module tb_mux32_serializer;

   typedef struct {
      bit       b;
      bit [4:0] s;
      bit       l;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] in_data = '0;
   logic [4:0]  in_len = '0;
   logic        in_valid = 1'b0;
   logic        sout_ready = 1'b0;

   logic        rdy_l, so_l, sv_l, last_l, busy_l;
   logic [4:0]  sel_l;
   logic        rdy_m, so_m, sv_m, last_m, busy_m;
   logic [4:0]  sel_m;

   int   checks = 0;
   int   failures = 0;
   int   ncyc = 0;
   int   ph = 0;
   bit   rand_rdy = 1'b0;
   bit   [3:0] pat = 4'b1111;
   bit   accepted;
   exp_t q_l[$];
   exp_t q_m[$];
   bit   rx_l[$];
   bit   rx_m[$];

   always #5 clk = ~clk;

   mux32_serializer #(.MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .rst(rst), .in_data(in_data), .in_len(in_len), .in_valid(in_valid),
      .in_ready(rdy_l), .sout(so_l), .sout_valid(sv_l), .sout_ready(sout_ready),
      .sout_last(last_l), .sel(sel_l), .busy(busy_l)
   );

   mux32_serializer #(.MSB_FIRST(1'b1)) dut_msb (
      .clk(clk), .rst(rst), .in_data(in_data), .in_len(in_len), .in_valid(in_valid),
      .in_ready(rdy_m), .sout(so_m), .sout_valid(sv_m), .sout_ready(sout_ready),
      .sout_last(last_m), .sel(sel_m), .busy(busy_m)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit next_rdy();
      bit r;
      r  = rand_rdy ? bit'($urandom_range(0, 1)) : pat[3 - (ph % 4)];
      ph = ph + 1;
      return r;
   endfunction

   // Reference: a word becomes the list of (bit, position, last) in transmit order.
   task automatic push_word(input logic [31:0] d, input logic [4:0] l);
      exp_t e;
      for (int i = 0; i <= int'(l); i++) begin
         e.s = 5'(i);
         e.b = d[i];
         e.l = (i == int'(l));
         q_l.push_back(e);
         e.s = 5'(int'(l) - i);
         e.b = d[int'(l) - i];
         q_m.push_back(e);
      end
   endtask

   task automatic cycle(input bit v, input logic [31:0] d, input logic [4:0] l, input bit r);
      bit   m_rdy;
      exp_t e;
      @(negedge clk);
      in_valid = v; in_data = d; in_len = l; sout_ready = r;
      #1;
      m_rdy = (q_l.size() == 0) || (q_l.size() == 1 && r);
      chk("in_ready_lsb", rdy_l, m_rdy);
      chk("in_ready_msb", rdy_m, m_rdy);
      if (q_l.size() > 0) begin
         e = q_l[0];
         chk("valid_lsb", sv_l, 1); chk("bit_lsb", so_l, e.b);
         chk("sel_lsb", sel_l, e.s); chk("last_lsb", last_l, e.l); chk("busy_lsb", busy_l, 1);
         e = q_m[0];
         chk("valid_msb", sv_m, 1); chk("bit_msb", so_m, e.b);
         chk("sel_msb", sel_m, e.s); chk("last_msb", last_m, e.l); chk("busy_msb", busy_m, 1);
      end else begin
         chk("valid_lsb", sv_l, 0); chk("last_lsb", last_l, 0); chk("busy_lsb", busy_l, 0);
         chk("valid_msb", sv_m, 0); chk("last_msb", last_m, 0); chk("busy_msb", busy_m, 0);
      end
      if (q_l.size() > 0 && r) begin
         rx_l.push_back(so_l);
         rx_m.push_back(so_m);
         q_l.delete(0);
         q_m.delete(0);
      end
      accepted = v && m_rdy;
      if (accepted) push_word(d, l);
      ncyc++;
   endtask

   task automatic send(input logic [31:0] d, input logic [4:0] l);
      int guard = 0;
      accepted = 1'b0;
      while (!accepted && guard < 100) begin
         cycle(1'b1, d, l, next_rdy());
         guard++;
      end
      if (!accepted) chk("accept_timeout", 0, 1);
   endtask

   task automatic drain();
      int guard = 0;
      while (q_l.size() > 0 && guard < 400) begin
         cycle(1'b0, $urandom, 5'($urandom), next_rdy());
         guard++;
      end
      if (q_l.size() > 0) chk("drain_timeout", q_l.size(), 0);
   endtask

   // Async reset pulse between clock edges, checked before any edge arrives.
   task automatic pulse_reset();
      @(negedge clk);
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("rst_valid_lsb", sv_l, 0); chk("rst_busy_lsb", busy_l, 0);
      chk("rst_ready_lsb", rdy_l, 1); chk("rst_sel_lsb", sel_l, 0);
      chk("rst_valid_msb", sv_m, 0); chk("rst_busy_msb", busy_m, 0);
      chk("rst_ready_msb", rdy_m, 1); chk("rst_sel_msb", sel_m, 0);
      q_l.delete();
      q_m.delete();
      #1 rst = 1'b0;
   endtask

   initial begin
      logic [31:0] word;
      int          c0;

      // Reset asserted mid-cycle, no clock edge in between.
      #3 rst = 1'b1;
      #1;
      chk("init_valid", sv_l, 0); chk("init_busy", busy_l, 0);
      chk("init_ready", rdy_l, 1); chk("init_sel", sel_l, 0);
      chk("init_sel_msb", sel_m, 0);
      @(negedge clk);
      rst = 1'b0;

      // LSB-first full word, ready held high.
      pat = 4'b1111; ph = 0; rx_l.delete(); rx_m.delete();
      send(32'hA5A5_0F0F, 5'd31);
      drain();
      word = '0;
      foreach (rx_l[i]) word[i] = rx_l[i];
      chk("full_count", rx_l.size(), 32);
      chk("full_word", word, 32'hA5A5_0F0F);
      cycle(1'b0, 32'h0, 5'd0, 1'b1);

      // Short word MSB-first: 1,0,1,0.
      rx_l.delete(); rx_m.delete();
      send(32'h0000_000A, 5'd3);
      drain();
      word = '0;
      foreach (rx_m[i]) word = {word[30:0], rx_m[i]};
      chk("short_msb_bits", word, 32'hA);
      chk("short_count", rx_m.size(), 4);
      cycle(1'b0, 32'h0, 5'd0, 1'b0);

      // Backpressure with ready pattern 1,0,0,1.
      pat = 4'b1001; ph = 0; rx_l.delete(); rx_m.delete();
      send(32'h0000_00C3, 5'd7);
      drain();
      word = '0;
      foreach (rx_l[i]) word = {word[30:0], rx_l[i]};
      chk("bp_bits_lsb", word, 32'b1100_0011);
      word = '0;
      foreach (rx_m[i]) word = {word[30:0], rx_m[i]};
      chk("bp_bits_msb", word, 32'b1100_0011);

      // Back-to-back: B loads on A's last bit, four bits on four cycles.
      pat = 4'b1111; ph = 0; rx_l.delete(); rx_m.delete();
      send(32'hFFFF_FFFF, 5'd1);
      c0 = ncyc;
      send(32'h0000_0000, 5'd1);
      chk("b2b_accept_cycle", ncyc - c0, 2);
      drain();
      chk("b2b_total_cycles", ncyc - c0, 4);
      word = '0;
      foreach (rx_l[i]) word = {word[30:0], rx_l[i]};
      chk("b2b_bits", word, 32'b1100);

      // Reset after 10 bits of a long word, then a single-bit word.
      send($urandom, 5'd31);
      for (int i = 0; i < 10; i++) cycle(1'b0, 32'h0, 5'd0, 1'b1);
      pulse_reset();
      cycle(1'b0, 32'h0, 5'd0, 1'b1);
      rx_l.delete(); rx_m.delete();
      send(32'h0000_0001, 5'd0);
      drain();
      chk("rst_mid_count", rx_l.size(), 1);
      if (rx_l.size() > 0) chk("rst_mid_bit", rx_l[0], 1);
      if (rx_m.size() > 0) chk("rst_mid_bit_msb", rx_m[0], 1);

      // Randomized words, lengths, gaps and ready.
      rand_rdy = 1'b1;
      for (int n = 0; n < 40; n++) begin
         logic [4:0] l;
         case ($urandom_range(0, 3))
            0:       l = 5'd0;
            1:       l = 5'd31;
            default: l = 5'($urandom);
         endcase
         send($urandom, l);
         if ($urandom_range(0, 3) == 0) begin
            drain();
            cycle(1'b0, $urandom, 5'($urandom), bit'($urandom_range(0, 1)));
         end
      end
      drain();
      cycle(1'b0, 32'h0, 5'd0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mux32_serializer.md
Name: mux32_serializer

Overview:
Sequencer for the 32:1 bit-select mux (`mux32`, 32-bit `in`, 5-bit select `ena`). It accepts a 32-bit word over a valid/ready handshake and captures it in a holding register. It then steps the mux select through a programmable number of bit positions, presenting one bit per transfer on a serial valid/ready output. It sits between a word-wide producer and any bit-serial consumer, for example a shift-out link or a serial debug port.

Parameters:
MSB_FIRST, 0, 0 = bit order ascending from bit 0; 1 = descending from bit `len`.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
in_data  input  32  word to serialize.
in_len  input  5  number of bits to send minus one (0 sends 1 bit, 31 sends 32); sampled with `in_data`.
in_valid  input  1  producer has a word.
in_ready  output  1  block can accept a word this cycle.
sout  output  1  current serial bit, equal to `data_q[sel]` via an internal `mux32` instance.
sout_valid  output  1  `sout` is valid.
sout_ready  input  1  consumer accepts `sout` this cycle.
sout_last  output  1  current bit is the final bit of the word.
sel  output  5  current mux select, for debug and observation.
busy  output  1  high in SHIFT.

Behaviour:
- Interface is fixed as decided: one clock, `clk`; reset `rst` is asynchronous and active-high.
- Internal registers:
  - `state` is IDLE or SHIFT.
  - `data_q[31:0]` holds the accepted word.
  - `sel[4:0]` is the current bit position.
  - `end_q[4:0]` is the final bit position.
- Reset (asynchronous, immediate):
  - state = IDLE; `data_q`, `sel`, `end_q` = 0.
  - `sout_valid` = 0, `sout_last` = 0, `busy` = 0.
  - `in_ready` = 1 while IDLE.
- Accept condition: `in_valid & in_ready`.
  - `in_ready` = (state == IDLE) | (`sout_valid & sout_ready & sout_last`).
- On accept:
  - `data_q` <= `in_data`.
  - If MSB_FIRST = 0: `sel` <= 0, `end_q` <= `in_len`.
  - If MSB_FIRST = 1: `sel` <= `in_len`, `end_q` <= 0.
  - state <= SHIFT.
- Latency: a word accepted at edge N has its first bit valid after edge N; no bubble cycle.
- In SHIFT:
  - `sout_valid` = 1.
  - `sout` = `data_q[sel]`.
  - `sout_last` = (`sel == end_q`).
- Bit transfer occurs on `sout_valid & sout_ready`.
  - Not last bit: `sel` increments (MSB_FIRST = 0) or decrements (MSB_FIRST = 1).
  - Last bit, no simultaneous accept: state <= IDLE, `sel` <= 0.
  - Last bit with a simultaneous accept: the new word loads exactly as in the accept rule; state stays SHIFT (back-to-back, zero bubble).
- Backpressure: while `sout_ready` = 0, `sel`, `data_q` and `sout` hold stable; no bit is dropped or repeated.
- `in_data` and `in_len` changes while not accepting have no effect; `data_q` is written only on accept.
- `sel` never wraps.
  - Ascending order stops at `end_q` ≤ 31.
  - Descending order stops at 0.
  - Counter overflow is unreachable by construction.
- `in_len` = 0: exactly one bit is sent, with `sout_last` = 1 on that bit.
- Reset mid-word: the remaining bits are discarded and `sout_valid` drops immediately. The next accepted word starts from its first bit.
- IDLE outputs: `sout_valid` = 0, `sout_last` = 0, `busy` = 0. `sout` = `data_q[0]` and has no meaning while IDLE.
- All outputs are derived from registers; no combinational path from `in_*` to `sout*`. `in_ready` has a combinational path from `sout_ready`.

Test Plan:
1. Reset: assert `rst` mid-cycle with no clock edge. Required: `sout_valid` = 0, `busy` = 0, `in_ready` = 1 and `sel` = 0 immediately.
2. LSB-first full word: MSB_FIRST = 0, `in_data` = 32'hA5A5_0F0F, `in_len` = 31, `sout_ready` held at 1. Required:
   - 32 consecutive valid bits: 1,1,1,1,0,0,0,0 repeating through bit 15, then 1,0,1,0,0,1,0,1 repeating through bit 31.
   - `sout_last` only on the 32nd bit, then IDLE.
3. Short word, MSB-first: MSB_FIRST = 1, `in_data` = 32'h0000_000A, `in_len` = 3. Required: bits 1,0,1,0 with `sel` 3,2,1,0, `sout_last` with `sel` = 0, then `in_ready` = 1.
4. Backpressure: `in_len` = 7, `in_data` = 32'h0000_00C3, `sout_ready` driven with a 1,0,0,1 repeating pattern. Required: `sel` advances only on cycles with `sout_ready` = 1; the received bit sequence is 1,1,0,0,0,0,1,1.
5. Back-to-back: word A = 32'hFFFF_FFFF with `in_len` = 1, word B = 32'h0 with `in_len` = 1, B held valid throughout. Required: B accepted in the same cycle as A's last bit; bits 1,1,0,0 on four consecutive cycles with no invalid gap.
6. Reset mid-word: `in_len` = 31, pulse `rst` after 10 bits, then send 32'h0000_0001 with `in_len` = 0. Required: no further bits from the first word; the next output is a single bit 1 with `sout_last` = 1.
